// File: rtl/ledpanel_rx_if.sv
// Control bus shared with the HUB75 panel driver: byte-addressed request held
// until a one-cycle done pulse.
interface ledpanel_rx_if;
  logic [3:0]  ctrl_wr;
  logic        ctrl_rd;
  logic [15:0] ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  input  ctrl_rdat, ctrl_done);
  modport slave  (input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/ledpanel_rx.sv
// HUB75 panel receiver: samples the panel pins, rebuilds each latched bit-plane
// into capture memories and serves them back over the ctrl bus.
module ledpanel_rx #(
  parameter int BITS_PER_CHANNEL = 4,
  parameter int SIZE             = 1,
  parameter int SIZE_BITS        = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         resetn,
  ledpanel_rx_if.slave ctrl,
  input  logic         panel_clk,
  input  logic         panel_stb,
  input  logic         panel_a,
  input  logic         panel_b,
  input  logic         panel_c,
  input  logic         panel_d,
  input  logic         panel_r0,
  input  logic         panel_g0,
  input  logic         panel_b0,
  input  logic         panel_r1,
  input  logic         panel_g1,
  input  logic         panel_b1,
  output logic         frame_pulse
);
  localparam int COLS  = 32 * SIZE;
  localparam int XW    = 5 + SIZE_BITS;
  localparam int CW    = 6 + SIZE_BITS;
  localparam int PW    = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
  localparam int AW    = PW + XW + 4;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {IDLE, COPY} copyState_t;
  typedef enum logic [1:0] {RIDLE, RPLANE, RDONE} readState_t;

  logic [11:0] pins, sync1_q, sync2_q;
  logic        clkDly_q, stbDly_q, clkEdge, stbEdge;
  logic [3:0]  rowIn;
  logic [5:0]  pixIn;

  logic [CW-1:0] col_q;
  logic          sel_q;
  logic [3:0]    row_q;
  logic [PW-1:0] plane_q;
  logic [15:0]   frameCount_q;
  logic          framePulse_q;
  logic          overflow_q, overrun_q, overflowSet, overrunSet, flagClear;

  logic [5:0] stage_q [2][COLS];
  logic [2:0] topMem_q [DEPTH];
  logic [2:0] botMem_q [DEPTH];

  copyState_t    copyState_q, copyState_d;
  logic [XW-1:0] copyX_q, copyX_d;
  logic          copyWe;
  logic [AW-1:0] copyAddr, rdMemAddr;
  logic [5:0]    copyPix;

  readState_t    readState_q, readState_d;
  logic [PW-1:0] rdPlane_q, rdPlane_d;
  logic [BITS_PER_CHANNEL-1:0] rAcc_q, rAcc_d, gAcc_q, gAcc_d, bAcc_q, bAcc_d;
  logic [2:0]    rdBits;
  logic          done_q, done_d;
  logic [31:0]   rdat_q, rdat_d, statusWord, pixelWord;
  logic          unusedBits;

  // Bit 11 = clk, 10 = stb, 9:6 = row {d,c,b,a}, 5:0 = {r1,g1,b1,r0,g0,b0}
  assign pins = {panel_clk, panel_stb, panel_d, panel_c, panel_b, panel_a,
                 panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      clkDly_q <= 1'b0;
      stbDly_q <= 1'b0;
    end else begin
      sync1_q  <= pins;
      sync2_q  <= sync1_q;
      clkDly_q <= sync2_q[11];
      stbDly_q <= sync2_q[10];
    end
  end

  assign clkEdge = sync2_q[11] & ~clkDly_q;
  assign stbEdge = sync2_q[10] & ~stbDly_q;
  assign rowIn   = sync2_q[9:6];
  assign pixIn   = sync2_q[5:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q        <= '0;
      sel_q        <= 1'b0;
      row_q        <= 4'hF;
      plane_q      <= '0;
      frameCount_q <= '0;
      framePulse_q <= 1'b0;
    end else begin
      framePulse_q <= 1'b0;
      if (stbEdge) begin
        col_q <= '0;
        sel_q <= ~sel_q;
        row_q <= rowIn;
        if (rowIn != row_q || plane_q == PW'(BITS_PER_CHANNEL - 1))
          plane_q <= '0;
        else
          plane_q <= plane_q + 1'b1;
        if (row_q == 4'hF && rowIn == 4'h0) begin
          frameCount_q <= frameCount_q + 1'b1;
          framePulse_q <= 1'b1;
        end
      end else if (clkEdge && col_q < CW'(COLS)) begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clkEdge && !stbEdge && col_q < CW'(COLS))
      stage_q[sel_q][col_q[XW-1:0]] <= pixIn;
  end

  assign overflowSet = clkEdge && !stbEdge && (col_q == CW'(COLS));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      copyState_q <= IDLE;
      copyX_q     <= '0;
    end else begin
      copyState_q <= copyState_d;
      copyX_q     <= copyX_d;
    end
  end

  // A new strobe always restarts the copy on the buffer that was just filled
  always_comb begin
    copyState_d = copyState_q;
    copyX_d     = copyX_q;
    copyWe      = 1'b0;
    overrunSet  = 1'b0;
    if (stbEdge) begin
      overrunSet  = (copyState_q == COPY);
      copyState_d = COPY;
      copyX_d     = '0;
    end else if (copyState_q == COPY) begin
      copyWe  = 1'b1;
      copyX_d = copyX_q + 1'b1;
      if (copyX_q == XW'(COLS - 1))
        copyState_d = IDLE;
    end
  end

  assign copyPix  = stage_q[~sel_q][copyX_q];
  assign copyAddr = {plane_q, copyX_q, row_q};

  always_ff @(posedge clk) begin
    if (copyWe) begin
      topMem_q[copyAddr] <= copyPix[2:0];
      botMem_q[copyAddr] <= copyPix[5:3];
    end
  end

  assign rdMemAddr = {rdPlane_q, ctrl.ctrl_addr[11+SIZE_BITS:7], ctrl.ctrl_addr[5:2]};
  assign rdBits    = ctrl.ctrl_addr[6] ? botMem_q[rdMemAddr] : topMem_q[rdMemAddr];
  assign statusWord = {frameCount_q, 14'b0, overrun_q, overflow_q};
  assign pixelWord  = {8'h00,
                       8'(rAcc_q) << (8 - BITS_PER_CHANNEL),
                       8'(gAcc_q) << (8 - BITS_PER_CHANNEL),
                       8'(bAcc_q) << (8 - BITS_PER_CHANNEL)};
  assign unusedBits = ^{ctrl.ctrl_wdat, ctrl.ctrl_addr};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      readState_q <= RIDLE;
      rdPlane_q   <= '0;
      rAcc_q      <= '0;
      gAcc_q      <= '0;
      bAcc_q      <= '0;
      done_q      <= 1'b0;
      rdat_q      <= '0;
      overflow_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      readState_q <= readState_d;
      rdPlane_q   <= rdPlane_d;
      rAcc_q      <= rAcc_d;
      gAcc_q      <= gAcc_d;
      bAcc_q      <= bAcc_d;
      done_q      <= done_d;
      rdat_q      <= rdat_d;
      overflow_q  <= overflowSet | (overflow_q & ~flagClear);
      overrun_q   <= overrunSet  | (overrun_q  & ~flagClear);
    end
  end

  // The cycle spent with done_q high is the mandatory gap before a held request restarts
  always_comb begin
    readState_d = readState_q;
    rdPlane_d   = rdPlane_q;
    rAcc_d      = rAcc_q;
    gAcc_d      = gAcc_q;
    bAcc_d      = bAcc_q;
    done_d      = 1'b0;
    rdat_d      = '0;
    flagClear   = 1'b0;
    case (readState_q)
      RIDLE: begin
        if (!done_q) begin
          if (ctrl.ctrl_wr != 4'h0) begin
            done_d    = 1'b1;
            flagClear = ctrl.ctrl_addr[15];
          end else if (ctrl.ctrl_rd) begin
            rdPlane_d   = '0;
            rAcc_d      = '0;
            gAcc_d      = '0;
            bAcc_d      = '0;
            readState_d = ctrl.ctrl_addr[15] ? RDONE : RPLANE;
          end
        end
      end
      RPLANE: begin
        rAcc_d[rdPlane_q] = rdBits[2];
        gAcc_d[rdPlane_q] = rdBits[1];
        bAcc_d[rdPlane_q] = rdBits[0];
        rdPlane_d = rdPlane_q + 1'b1;
        if (rdPlane_q == PW'(BITS_PER_CHANNEL - 1))
          readState_d = RDONE;
      end
      RDONE: begin
        done_d      = 1'b1;
        rdat_d      = ctrl.ctrl_addr[15] ? statusWord : pixelWord;
        readState_d = RIDLE;
      end
      default: readState_d = RIDLE;
    endcase
  end

  assign ctrl.ctrl_done = done_q;
  assign ctrl.ctrl_rdat = rdat_q;
  assign frame_pulse    = framePulse_q;
endmodule

// File: tb/tb_ledpanel_rx.sv
// Directed bench for ledpanel_rx: drives HUB75 lines through the pins and reads
// the captured frame and status back over the ctrl bus.
module tb_ledpanel_rx;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       panelClk, panelStb;
  logic [3:0] panelRow;
  logic [5:0] panelPix;
  logic       framePulse;

  int checks = 0;
  int failures = 0;
  int pulseCount = 0;
  int pulseBefore;
  int doneCount;
  int backToBack;
  bit prevDone;

  ledpanel_rx_if ctrlBus ();

  ledpanel_rx #(.BITS_PER_CHANNEL(B), .SIZE(1)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ctrl       (ctrlBus.slave),
    .panel_clk  (panelClk),
    .panel_stb  (panelStb),
    .panel_a    (panelRow[0]),
    .panel_b    (panelRow[1]),
    .panel_c    (panelRow[2]),
    .panel_d    (panelRow[3]),
    .panel_r0   (panelPix[2]),
    .panel_g0   (panelPix[1]),
    .panel_b0   (panelPix[0]),
    .panel_r1   (panelPix[5]),
    .panel_g1   (panelPix[4]),
    .panel_b1   (panelPix[3]),
    .frame_pulse(framePulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (framePulse === 1'b1) pulseCount++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] pixAddr(input int x, input int y);
    return 16'((x << 7) | (y << 2));
  endfunction

  task automatic panelShift(input logic [5:0] data);
    panelPix = data;
    waitCycles(2);
    panelClk = 1'b1;
    waitCycles(2);
    panelClk = 1'b0;
    waitCycles(1);
  endtask

  task automatic strobe(input int gap);
    panelStb = 1'b1;
    waitCycles(3);
    panelStb = 1'b0;
    waitCycles(gap - 3);
  endtask

  // One panel line: every column zero except hotCol; edges past 32 carry all-ones
  task automatic applyStimulus(input logic [3:0] row, input int edges, input int hotCol,
                               input logic [5:0] hotData);
    panelRow = row;
    for (int c = 0; c < edges; c++)
      panelShift((c == hotCol) ? hotData : ((c >= 32) ? 6'h3F : 6'h00));
    panelPix = 6'h00;
    strobe(45);
  endtask

  task automatic busAccess(input string tag, input logic [3:0] wr, input logic [15:0] addr,
                           input int expLat, input logic [31:0] expData);
    int lat;
    logic [31:0] got;
    lat = 0;
    ctrlBus.ctrl_wr   = wr;
    ctrlBus.ctrl_rd   = (wr == 4'h0);
    ctrlBus.ctrl_addr = addr;
    ctrlBus.ctrl_wdat = 32'hDEAD_BEEF;
    do begin
      @(negedge clk);
      lat++;
    end while (ctrlBus.ctrl_done !== 1'b1 && lat < 20);
    got = ctrlBus.ctrl_rdat;
    ctrlBus.ctrl_wr = 4'h0;
    ctrlBus.ctrl_rd = 1'b0;
    checkOutput({tag, "Lat"}, 32'(lat), 32'(expLat));
    if (wr == 4'h0) checkOutput(tag, got, expData);
    waitCycles(2);
  endtask

  initial begin
    resetn   = 1'b0;
    panelClk = 1'b0;
    panelStb = 1'b0;
    panelRow = 4'h0;
    panelPix = 6'h00;
    ctrlBus.ctrl_wr   = 4'h0;
    ctrlBus.ctrl_rd   = 1'b0;
    ctrlBus.ctrl_addr = 16'h0000;
    ctrlBus.ctrl_wdat = 32'h0;
    waitCycles(3);
    checkOutput("resetDone", 32'(ctrlBus.ctrl_done), 32'h0);
    checkOutput("resetRdat", ctrlBus.ctrl_rdat, 32'h0);
    checkOutput("resetPulse", 32'(framePulse), 32'h0);
    resetn = 1'b1;
    waitCycles(2);
    busAccess("statusAfterReset", 4'h0, 16'h8000, 2, 32'h0);
    busAccess("statusClearIdle", 4'hF, 16'h8000, 1, 32'h0);

    $display("[TB] single row");
    for (int p = 0; p < B; p++) applyStimulus(4'd3, 32, -1, 6'h00);
    applyStimulus(4'd3, 32, 5, 6'b000100);
    busAccess("pix5_3", 4'h0, pixAddr(5, 3), B + 2, 32'h0010_0000);
    busAccess("pix5_19", 4'h0, pixAddr(5, 19), B + 2, 32'h0);
    busAccess("pix4_3", 4'h0, pixAddr(4, 3), B + 2, 32'h0);

    $display("[TB] plane accumulation");
    applyStimulus(4'd7, 32, 0, 6'b010000);
    applyStimulus(4'd7, 32, -1, 6'h00);
    applyStimulus(4'd7, 32, 0, 6'b010000);
    applyStimulus(4'd7, 32, -1, 6'h00);
    busAccess("pix0_23", 4'h0, pixAddr(0, 23), B + 2, 32'h0000_5000);
    busAccess("pix0_7", 4'h0, pixAddr(0, 7), B + 2, 32'h0);
    checkOutput("noFrameYet", 32'(pulseCount), 32'h0);

    $display("[TB] frame counting");
    pulseBefore = pulseCount;
    for (int r = 0; r < 16; r++) applyStimulus(4'(r), 32, -1, 6'h00);
    applyStimulus(4'd0, 32, -1, 6'h00);
    checkOutput("framePulses", 32'(pulseCount - pulseBefore), 32'h1);
    busAccess("statusFrame", 4'h0, 16'h8000, 2, 32'h0001_0000);

    $display("[TB] overflow");
    applyStimulus(4'd9, 33, 0, 6'b000001);
    for (int p = 1; p < B; p++) applyStimulus(4'd9, 32, -1, 6'h00);
    busAccess("statusOverflow", 4'h0, 16'h8000, 2, 32'h0001_0001);
    busAccess("pix0_9", 4'h0, pixAddr(0, 9), B + 2, 32'h0000_0010);
    busAccess("statusClear", 4'h3, 16'h8000, 1, 32'h0);
    busAccess("statusCleared", 4'h0, 16'h8000, 2, 32'h0001_0000);

    $display("[TB] overrun");
    for (int p = 0; p < B; p++) applyStimulus(4'd11, 32, -1, 6'h00);
    applyStimulus(4'd11, 32, 31, 6'b100000);
    applyStimulus(4'd11, 32, 31, 6'b010000);
    strobe(10);
    strobe(45);
    busAccess("statusOverrun", 4'h0, 16'h8000, 2, 32'h0001_0002);
    busAccess("pix31_27", 4'h0, pixAddr(31, 27), B + 2, 32'h0010_A000);
    busAccess("pix0_27", 4'h0, pixAddr(0, 27), B + 2, 32'h0);
    busAccess("pixelWriteDone", 4'h1, pixAddr(31, 27), 1, 32'h0);

    $display("[TB] held request");
    doneCount  = 0;
    backToBack = 0;
    prevDone   = 1'b0;
    ctrlBus.ctrl_addr = 16'h8000;
    ctrlBus.ctrl_rd   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ctrlBus.ctrl_done === 1'b1) begin
        doneCount++;
        if (prevDone) backToBack++;
      end
      prevDone = (ctrlBus.ctrl_done === 1'b1);
    end
    ctrlBus.ctrl_rd = 1'b0;
    waitCycles(4);
    checkOutput("heldDones", 32'(doneCount), 32'h3);
    checkOutput("heldBackToBack", 32'(backToBack), 32'h0);

    $display("[TB] reset during pixel read");
    ctrlBus.ctrl_addr = pixAddr(31, 27);
    ctrlBus.ctrl_rd   = 1'b1;
    waitCycles(2);
    resetn = 1'b0;
    #1;
    checkOutput("midReadDone", 32'(ctrlBus.ctrl_done), 32'h0);
    checkOutput("midReadRdat", ctrlBus.ctrl_rdat, 32'h0);
    checkOutput("midReadPulse", 32'(framePulse), 32'h0);
    ctrlBus.ctrl_rd = 1'b0;
    doneCount = 0;
    repeat (4) begin
      @(negedge clk);
      if (ctrlBus.ctrl_done === 1'b1) doneCount++;
    end
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (ctrlBus.ctrl_done === 1'b1) doneCount++;
    end
    checkOutput("midReadNoDone", 32'(doneCount), 32'h0);
    busAccess("pixAfterReset", 4'h0, pixAddr(31, 27), B + 2, 32'h0010_A000);
    busAccess("statusAfterReset2", 4'h0, 16'h8000, 2, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
